image_rom_arbiter: RTL

Round-robin arbiter that shares one synchronous image ROM (14-bit address, 12-bit RGB, 1-cycle registered read) between several sprite/draw requesters. Each requester issues single-pixel reads; the arbiter grants at most one per cycle, drives the shared ROM address, and returns the read data with a one-hot valid tagged to the original requester. It sits between the draw-image pipelines and a single image ROM instance, so that several on-screen objects can use one ROM.

---
 rtl/image_rom_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image ROM between N_REQ pixel requesters.
// Grants are combinational; read data returns two cycles later with a one-hot owner tag.
module image_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_rgb,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_ptr_next;
  logic              w_any;
  int unsigned       w_j;
  logic [N_REQ-1:0]  w_gnt;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [N_REQ-1:0]  r_tag1;
  logic [N_REQ-1:0]  r_tag2;

  // Search from the pointer, wrapping at N_REQ (not at a power of two).
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_j = (32'(r_ptr) + k) % N_REQ;
      if (!w_any && req[w_j[PTR_W-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_j[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt      = '0;
    w_sel_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_any && (i[PTR_W-1:0] == w_idx)) begin
        w_gnt[i[PTR_W-1:0]] = 1'b1;
        w_sel_addr          = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // A locked winner keeps top priority; otherwise priority rotates past it.
  always_comb begin
    if (lock[w_idx])
      w_ptr_next = w_idx;
    else if (w_idx == PTR_W'(N_REQ - 1))
      w_ptr_next = '0;
    else
      w_ptr_next = w_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
    end else begin
      r_tag2 <= r_tag1;
      if (w_any) begin
        r_ptr      <= w_ptr_next;
        r_rom_addr <= w_sel_addr;
        r_tag1     <= w_gnt;
      end else begin
        r_tag1 <= '0;
      end
    end
  end

  assign gnt      = w_gnt;
  assign rom_addr = r_rom_addr;
  assign rd_valid = r_tag2;
  assign rd_data  = rom_rgb;

endmodule
